// File: rtl/sort_batch_scheduler.sv
// sort_batch_scheduler: gathers per-lane requests into batches for an
// external odd-even sorter and buffers sorted batches under credit control.
`ifndef PORT_NUB_TOTAL
`define PORT_NUB_TOTAL 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module sort_batch_scheduler #(
  parameter int PORT_NUB  = 4,
  parameter int SORT_LAT  = 3,
  parameter int WAIT_MAX  = 8,
  parameter int BUF_DEPTH = 4,
  localparam int DW = $clog2(`PORT_NUB_TOTAL),
  localparam int XW = `DATA_WIDTH,
  localparam int WP = 2*DW+XW,
  localparam int WT = PORT_NUB*WP
)(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [PORT_NUB-1:0]    in_valid,
  output logic [PORT_NUB-1:0]    in_ready,
  input  logic [PORT_NUB*DW-1:0] in_dest,
  input  logic [PORT_NUB*XW-1:0] in_data,
  output logic [WT-1:0]          sort_in,
  input  logic [WT-1:0]          sort_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WT-1:0]          out_port,
  output logic [PORT_NUB-1:0]    out_mask,
  output logic                   busy
);

  localparam int TW = $clog2(WAIT_MAX+1);
  localparam int CW = $clog2(BUF_DEPTH+1);
  localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [TW-1:0] T_MAX = TW'(WAIT_MAX-1);
  localparam logic [CW-1:0] C_MAX = CW'(BUF_DEPTH);
  localparam logic [AW-1:0] P_MAX = AW'(BUF_DEPTH-1);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [CW-1:0] credits;
  logic launch, all_v, any_v, has_credit;

  logic [WT-1:0] batch;
  logic [SORT_LAT-1:0] dl_v;
  logic [PORT_NUB-1:0] dl_m [SORT_LAT];
  logic [PORT_NUB-1:0] mask_p;

  logic [WT-1:0] fq_d [BUF_DEPTH];
  logic [PORT_NUB-1:0] fq_m [BUF_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic push, pop, full;

  assign all_v = &in_valid;
  assign any_v = |in_valid;
  assign has_credit = (credits != '0);

  // state and wait-timer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
    end
  end

  // next-state, timer and launch strobe; no launch while held in reset
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    launch = 1'b0;
    unique case (state)
      IDLE: begin
        if (all_v && has_credit) begin
          launch = rst_n;
        end else if (any_v) begin
          state_nxt = COLLECT;
          timer_nxt = '0;
        end
      end
      COLLECT: begin
        if (!any_v) begin
          state_nxt = IDLE;
          timer_nxt = '0;
        end else if (has_credit && (all_v || timer == T_MAX)) begin
          launch = rst_n;
          state_nxt = IDLE;
          timer_nxt = '0;
        end else if (timer != T_MAX) begin
          timer_nxt = timer + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready = {PORT_NUB{launch}} & in_valid;

  // pack lanes; idle lanes become max-key bubbles so they sort last
  always_comb begin
    batch = '0;
    for (int i = 0; i < PORT_NUB; i++) begin
      if (in_valid[i])
        batch[i*WP +: WP] = {in_dest[i*DW +: DW], DW'(i),
                             in_data[i*XW +: XW]};
      else
        batch[i*WP +: WP] = {{DW{1'b1}}, DW'(i), {XW{1'b0}}};
    end
  end

  // sorter input register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sort_in <= '0;
    else        sort_in <= launch ? batch : '0;
  end

  // valid/mask delay line tracking batches inside the sorter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_v <= '0;
      for (int k = 0; k < SORT_LAT; k++) dl_m[k] <= '0;
    end else begin
      dl_v[0] <= launch;
      dl_m[0] <= launch ? in_valid : '0;
      for (int k = 1; k < SORT_LAT; k++) begin
        dl_v[k] <= dl_v[k-1];
        dl_m[k] <= dl_m[k-1];
      end
    end
  end

  // follow each sorted lane back to its source lane's valid bit
  always_comb begin
    mask_p = '0;
    for (int j = 0; j < PORT_NUB; j++)
      for (int k = 0; k < PORT_NUB; k++)
        if (sort_out[j*WP+XW +: DW] == DW'(k))
          mask_p[j] = dl_m[SORT_LAT-1][k];
  end

  assign push = dl_v[SORT_LAT-1];
  assign full = (count == C_MAX);
  assign out_valid = (count != '0);
  assign pop = out_valid & out_ready;
  assign out_port = out_valid ? fq_d[rd_ptr] : '0;
  assign out_mask = out_valid ? fq_m[rd_ptr] : '0;

  // batch FIFO storage
  always_ff @(posedge clk) begin
    if (push) begin
      fq_d[wr_ptr] <= sort_out;
      fq_m[wr_ptr] <= mask_p;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == P_MAX) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == P_MAX) ? '0 : rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // credits: one per FIFO slot, taken at launch, returned at pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits <= C_MAX;
    end else if (launch && !pop) begin
      credits <= credits - 1'b1;
    end else if (pop && !launch) begin
      credits <= credits + 1'b1;
    end
  end

  assign busy = (state != IDLE) | (credits != C_MAX);

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: tb/tb_sort_batch_scheduler.sv
// tb_sort_batch_scheduler: random and directed batches checked against
// a transaction-level model of batching, credits and sorted output.
`ifndef PORT_NUB_TOTAL
`define PORT_NUB_TOTAL 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module tb_sort_batch_scheduler;

  localparam int PN = 4;
  localparam int SL = 3;
  localparam int WM = 8;
  localparam int BD = 4;
  localparam int DW = $clog2(`PORT_NUB_TOTAL);
  localparam int XW = `DATA_WIDTH;
  localparam int WP = 2*DW+XW;
  localparam int WT = PN*WP;

  logic clk = 1'b0;
  logic rst_n;
  logic [PN-1:0] in_valid, in_ready;
  logic [PN*DW-1:0] in_dest;
  logic [PN*XW-1:0] in_data;
  logic [WT-1:0] sort_in, sort_out, out_port;
  logic out_valid, out_ready, busy;
  logic [PN-1:0] out_mask;

  sort_batch_scheduler #(
    .PORT_NUB(PN), .SORT_LAT(SL),
    .WAIT_MAX(WM), .BUF_DEPTH(BD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_dest(in_dest), .in_data(in_data),
    .sort_in(sort_in), .sort_out(sort_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_port(out_port), .out_mask(out_mask),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // ascending by {dest, src}
  function automatic logic [WT-1:0] sort_batch(input logic [WT-1:0] b);
    logic [WP-1:0] w [PN];
    logic [WP-1:0] t;
    logic [WT-1:0] r;
    for (int i = 0; i < PN; i++) w[i] = b[i*WP +: WP];
    for (int a = 0; a < PN; a++)
      for (int c = 0; c < PN-1-a; c++)
        if (w[c][WP-1:XW] > w[c+1][WP-1:XW]) begin
          t = w[c]; w[c] = w[c+1]; w[c+1] = t;
        end
    for (int i = 0; i < PN; i++) r[i*WP +: WP] = w[i];
    return r;
  endfunction

  // sorter stand-in: batch on sort_in reappears sorted SL-1 cycles later
  logic [WT-1:0] pipe [SL-1];
  initial for (int k = 0; k < SL-1; k++) pipe[k] = '0;
  always @(posedge clk) begin
    pipe[0] <= sort_batch(sort_in);
    for (int k = 1; k < SL-1; k++) pipe[k] <= pipe[k-1];
  end
  assign sort_out = pipe[SL-2];

  typedef struct {
    logic [WT-1:0] port;
    logic [PN-1:0] mask;
    int arrive;
  } exp_t;

  exp_t q[$];
  bit collecting;
  int waited;
  int cyc;
  int n_chk, n_pass, n_launch;
  logic [PN-1:0] acc;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  tag, got, exp, cyc);
  endtask

  function automatic exp_t make_exp(input int at);
    exp_t e;
    logic [WT-1:0] raw;
    logic [DW-1:0] s;
    for (int i = 0; i < PN; i++)
      raw[i*WP +: WP] = in_valid[i] ?
        {in_dest[i*DW +: DW], DW'(i), in_data[i*XW +: XW]} :
        {{DW{1'b1}}, DW'(i), {XW{1'b0}}};
    e.port = sort_batch(raw);
    for (int j = 0; j < PN; j++) begin
      s = e.port[j*WP+XW +: DW];
      e.mask[j] = in_valid[s];
    end
    e.arrive = at;
    return e;
  endfunction

  task automatic tick();
    logic [PN-1:0] exp_rdy;
    bit lau, all, any, exp_ov;
    int free;
    @(negedge clk);
    free = BD - q.size();
    all = &in_valid;
    any = |in_valid;
    lau = 0;
    if (!collecting) lau = all && free > 0;
    else if (any) lau = free > 0 && (all || waited >= WM-1);
    exp_rdy = lau ? in_valid : '0;
    exp_ov = q.size() > 0 && q[0].arrive <= cyc;
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, exp_ov);
    chk("busy", busy, collecting || q.size() > 0);
    if (exp_ov && q.size() > 0) begin
      chk("out_port", out_port, q[0].port);
      chk("out_mask", out_mask, q[0].mask);
    end
    acc = in_ready;
    if (in_ready != '0) n_launch++;
    if (exp_ov && out_ready) void'(q.pop_front());
    if (lau) q.push_back(make_exp(cyc + SL + 1));
    if (!collecting) begin
      collecting = !lau && any;
      waited = 0;
    end else if (!any || lau) begin
      collecting = 0;
    end else if (waited < WM-1) begin
      waited++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive_rand();
    for (int i = 0; i < PN; i++) begin
      if (in_valid[i] && acc[i]) in_valid[i] = 1'b0;
      if (!in_valid[i] && $urandom_range(3) == 0) begin
        in_valid[i] = 1'b1;
        in_dest[i*DW +: DW] = DW'($urandom);
        in_data[i*XW +: XW] = XW'($urandom);
      end else if (in_valid[i] && $urandom_range(15) == 0) begin
        in_valid[i] = 1'b0;
      end
    end
    out_ready = ($urandom_range(3) != 0);
  endtask

  task automatic drain(input int n);
    in_valid = '0;
    out_ready = 1'b1;
    repeat (n) tick();
  endtask

  task automatic rand_data();
    for (int i = 0; i < PN; i++) in_data[i*XW +: XW] = XW'($urandom);
  endtask

  task automatic wait_launch(input string tag, input int exp_n);
    int n;
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      n = k;
      if (acc != '0) break;
    end
    chk(tag, n, exp_n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    n_chk = 0; n_pass = 0; n_launch = 0;
    cyc = 0; collecting = 0; waited = 0; acc = '0;
    rst_n = 1'b0;
    in_valid = '1;
    in_dest = '0;
    in_data = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sort_in", sort_in, 0);
    chk("rst_out_port", out_port, 0);
    chk("rst_out_mask", out_mask, 0);
    in_valid = '0;
    rst_n = 1'b1;

    // full batch, dests 3,0,2,1
    in_dest = {2'd1, 2'd2, 2'd0, 2'd3};
    rand_data();
    in_valid = '1;
    tick();
    chk("full_ready", acc, 4'hF);
    drain(SL + 3);

    // partial timeout: lane 2 only, dest 1
    in_dest = '0;
    in_dest[2*DW +: DW] = 2'd1;
    rand_data();
    in_valid = 4'b0100;
    wait_launch("timeout_cycles", WM + 1);
    drain(SL + 3);

    // lane 0 with all-ones dest ties with bubbles
    in_dest[0 +: DW] = '1;
    in_valid = 4'b0001;
    wait_launch("tie_cycles", WM + 1);
    drain(SL + 3);

    // withdraw after two cycles
    base = n_launch;
    in_valid = 4'b0010;
    repeat (2) tick();
    in_valid = '0;
    repeat (2) tick();
    chk("withdraw_launches", n_launch - base, 0);
    chk("withdraw_busy", busy, 0);

    // backpressure
    base = n_launch;
    out_ready = 1'b0;
    in_valid = '1;
    for (int k = 0; k < 15; k++) begin
      in_dest = PN*DW'($urandom);
      rand_data();
      tick();
    end
    chk("bp_launches", n_launch - base, BD);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    repeat (8) tick();
    chk("bp_one_more", n_launch - base, BD + 1);
    drain(20);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      drive_rand();
      tick();
    end
    drain(30);

    // reset with two batches in flight
    in_valid = '1;
    repeat (2) begin
      in_dest = PN*DW'($urandom);
      rand_data();
      tick();
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    in_valid = '0;
    rst_n = 1'b1;
    q.delete();
    collecting = 0;
    waited = 0;
    repeat (SL + 4) tick();
    chk("post_rst_busy", busy, 0);
    in_dest = {2'd0, 2'd1, 2'd2, 2'd3};
    rand_data();
    in_valid = '1;
    tick();
    drain(SL + 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
